// File: rtl/mem_req_scheduler.sv
// Round-robin scheduler sharing one tagged memory port among NUM_REQ requesters,
// with multiple outstanding loads routed back by tag. Optional perf counters: MEM_SCHED_PERF_EN.
module mem_req_lane #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 64
) (
  input  logic [1:0]        cmd,
  input  logic              full,
  input  logic              ack_sel,
  input  logic [TAG_W-1:0]  ack_tag,
  input  logic              ret_sel,
  input  logic [TAG_W-1:0]  ret_tag,
  input  logic [DATA_W-1:0] ret_data,
  output logic              elig,
  output logic [TAG_W-1:0]  response,
  output logic [TAG_W-1:0]  tag,
  output logic [DATA_W-1:0] rdata
);
  // Loads wait while the tag table is full; stores never do.
  assign elig     = (cmd != 2'd0) && !((cmd == 2'd1) && full);
  assign response = ack_sel ? ack_tag  : '0;
  assign tag      = ret_sel ? ret_tag  : '0;
  assign rdata    = ret_sel ? ret_data : '0;
endmodule

module mem_req_scheduler #(
  parameter int NUM_REQ         = 3,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0][1:0]   req_command,
  input  logic [NUM_REQ-1:0][31:0]  req_address,
  input  logic [NUM_REQ-1:0][63:0]  req_wdata,
  output logic [NUM_REQ-1:0][3:0]   req_response,
  output logic [NUM_REQ-1:0][3:0]   req_tag,
  output logic [NUM_REQ-1:0][63:0]  req_rdata,
  input  logic [3:0]                mem2proc_response,
  input  logic [3:0]                mem2proc_tag,
  input  logic [63:0]               mem2proc_rdata,
  output logic [1:0]                proc2mem_command,
  output logic [31:0]               proc2mem_address,
  output logic [63:0]               proc2mem_wdata,
`ifdef MEM_SCHED_PERF_EN
  output logic [31:0]               perf_accepts,
  output logic [31:0]               perf_retry_cycles,
`endif
  output logic                      err_bad_tag
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {IDLE, ISSUE} state_t;
  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] owner;
  } tbl_ent_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    rr_ptr, gnt_id, pick_id;
  logic               pick_vld;
  tbl_ent_t [15:0]    own_tbl;
  logic [3:0]         outstanding;
  logic               full;
  logic [NUM_REQ-1:0] elig;
  logic [1:0]         gnt_cmd;
  logic               accept, load_acc, ret_hit, ret_bad;
  tbl_ent_t           ret_ent;

  assign full     = (outstanding >= 4'(MAX_OUTSTANDING));
  assign gnt_cmd  = req_command[gnt_id];
  assign load_acc = accept && (gnt_cmd == BUS_LOAD);
  assign ret_ent  = own_tbl[mem2proc_tag];
  assign ret_hit  = (mem2proc_tag != 4'd0) && ret_ent.vld;
  assign ret_bad  = (mem2proc_tag != 4'd0) && !ret_ent.vld;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    mem_req_lane #(.TAG_W(4), .DATA_W(64)) u_lane (
      .cmd      (req_command[g]),
      .full     (full),
      .ack_sel  (accept && (gnt_id == ID_W'(g))),
      .ack_tag  (mem2proc_response),
      .ret_sel  (ret_hit && (ret_ent.owner == ID_W'(g))),
      .ret_tag  (mem2proc_tag),
      .ret_data (mem2proc_rdata),
      .elig     (elig[g]),
      .response (req_response[g]),
      .tag      (req_tag[g]),
      .rdata    (req_rdata[g])
    );
  end

  // Two passes: indices at/above rr_ptr first, then wrap to those below it.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && elig[i] && (ID_W'(i) >= rr_ptr)) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pick_vld && elig[i] && (ID_W'(i) < rr_ptr)) begin
        pick_vld = 1'b1;
        pick_id  = ID_W'(i);
      end
    end
  end

  always_comb begin
    state_nxt        = state;
    accept           = 1'b0;
    proc2mem_command = BUS_NONE;
    proc2mem_address = '0;
    proc2mem_wdata   = '0;
    case (state)
      IDLE: if (pick_vld) state_nxt = ISSUE;
      ISSUE: begin
        proc2mem_command = gnt_cmd;
        proc2mem_address = req_address[gnt_id];
        proc2mem_wdata   = req_wdata[gnt_id];
        if (gnt_cmd == BUS_NONE) begin
          state_nxt = IDLE;
        end else if (mem2proc_response != 4'd0) begin
          accept    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      gnt_id      <= '0;
      own_tbl     <= '0;
      outstanding <= '0;
      err_bad_tag <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && pick_vld) gnt_id <= pick_id;
      if (accept) rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
      // Clear before set so a same-tag return+accept leaves the new owner.
      if (ret_hit)  own_tbl[mem2proc_tag].vld <= 1'b0;
      if (load_acc) own_tbl[mem2proc_response] <= '{vld: 1'b1, owner: gnt_id};
      outstanding <= outstanding + {3'b0, load_acc} - {3'b0, ret_hit};
      if (ret_bad) err_bad_tag <= 1'b1;
    end
  end

`ifdef MEM_SCHED_PERF_EN
  logic retry_cyc;
  assign retry_cyc = (state == ISSUE) && (gnt_cmd != BUS_NONE) && (mem2proc_response == 4'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_accepts      <= '0;
      perf_retry_cycles <= '0;
    end else begin
      if (accept && (perf_accepts != 32'hFFFF_FFFF))
        perf_accepts <= perf_accepts + 32'd1;
      if (retry_cyc && (perf_retry_cycles != 32'hFFFF_FFFF))
        perf_retry_cycles <= perf_retry_cycles + 32'd1;
    end
  end
`endif
endmodule
